// File: rtl/reg_alu_seq_pkg.sv
// reg_alu_seq_pkg: instruction encodings, field positions and sequencer states
package reg_alu_seq_pkg;
   localparam int DATA_W = 16;
   localparam int KIND_HI = 15, KIND_LO = 14;
   localparam int OP_HI = 13, OP_LO = 12;
   localparam int ALU_RD_HI = 11, ALU_RD_LO = 9;
   localparam int RA_HI = 8, RA_LO = 6;
   localparam int RB_HI = 5, RB_LO = 3;
   localparam int LDI_RD_HI = 13, LDI_RD_LO = 11;
   localparam int IMM_HI = 10, IMM_LO = 0;
   typedef enum logic [1:0] {
      KIND_ALU  = 2'b00,
      KIND_LDI  = 2'b01,
      KIND_NOP  = 2'b10,
      KIND_HALT = 2'b11
   } kind_t;
   typedef enum logic [2:0] {S_IDLE, S_READ, S_EXEC, S_FLAG, S_LDIW, S_NOPW, S_HALT} state_t;
   function automatic state_t accept_state(input logic [1:0] kind);
      return kind == KIND_ALU ? S_READ : kind == KIND_LDI ? S_LDIW : kind == KIND_NOP ? S_NOPW : S_HALT;
   endfunction
endpackage

// File: rtl/reg_alu_dec.sv
// reg_alu_dec: splits the latched instruction word into its fields
module reg_alu_dec
   import reg_alu_seq_pkg::*;
(
   input  logic [15:0]       ir,
   output logic [1:0]        kind,
   output logic [1:0]        op,
   output logic [2:0]        rd,
   output logic [2:0]        ra,
   output logic [2:0]        rb,
   output logic [DATA_W-1:0] imm
);
   logic unused_bits;
   assign unused_bits = ^ir[RB_LO-1:0];
   assign kind = ir[KIND_HI:KIND_LO];
   assign op   = ir[OP_HI:OP_LO];
   assign rd   = kind == KIND_LDI ? ir[LDI_RD_HI:LDI_RD_LO] : ir[ALU_RD_HI:ALU_RD_LO];
   assign ra   = ir[RA_HI:RA_LO];
   assign rb   = ir[RB_HI:RB_LO];
   assign imm  = {{(DATA_W - IMM_HI - 1){1'b0}}, ir[IMM_HI:IMM_LO]};
endmodule

// File: rtl/reg_alu_seq.sv
// reg_alu_seq: multi-cycle instruction sequencer driving the reg_alu control inputs
module reg_alu_seq
   import reg_alu_seq_pkg::*;
#(
   parameter int CNT_W = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              instr_valid,
   input  logic [15:0]       instr,
   output logic              instr_ready,
   output logic              sel,
   output logic              wr,
   output logic [1:0]        op,
   output logic [2:0]        rd_addr_a,
   output logic [2:0]        rd_addr_b,
   output logic [2:0]        wr_addr,
   output logic [DATA_W-1:0] d_in,
   input  logic              cout,
   output logic              carry_flag,
   output logic              done,
   output logic              halted,
   output logic [CNT_W-1:0]  retired
);
   state_t state;
   logic [15:0] ir;
   logic [1:0] kind_unused, dec_op;
   logic [2:0] rd, ra, rb;
   logic [DATA_W-1:0] imm;
   logic alu_act;

   reg_alu_dec u_dec (.ir(ir), .kind(kind_unused), .op(dec_op), .rd(rd), .ra(ra), .rb(rb), .imm(imm));

   // Outputs depend only on state and ir, so an async reset kills wr at once.
   assign alu_act     = state == S_READ || state == S_EXEC;
   assign instr_ready = state == S_IDLE;
   assign wr          = state == S_EXEC || state == S_LDIW;
   assign sel         = state == S_LDIW;
   assign op          = alu_act ? dec_op : '0;
   assign rd_addr_a   = alu_act ? ra : '0;
   assign rd_addr_b   = alu_act ? rb : '0;
   assign wr_addr     = wr ? rd : '0;
   assign d_in        = sel ? imm : '0;
   assign done        = state == S_FLAG || state == S_LDIW || state == S_NOPW || (state == S_HALT && !halted);

   always_ff @(posedge clk or negedge reset)
      if (!reset) begin
         state      <= S_IDLE;
         ir         <= '0;
         carry_flag <= 1'b0;
         retired    <= '0;
         halted     <= 1'b0;
      end else begin
         if (done) retired <= retired + CNT_W'(1);
         case (state)
            S_IDLE: if (instr_valid) begin
               ir    <= instr;
               state <= accept_state(instr[KIND_HI:KIND_LO]);
            end
            S_READ: state <= S_EXEC;
            S_EXEC: state <= S_FLAG;
            S_FLAG: begin
               carry_flag <= cout;
               state      <= S_IDLE;
            end
            S_LDIW, S_NOPW: state <= S_IDLE;
            S_HALT: halted <= 1'b1;
            default: state <= S_IDLE;
         endcase
      end
endmodule

// File: tb/tb_reg_alu_seq.sv
// tb_reg_alu_seq: scoreboard bench with an ISA-level model and a behavioural reg_alu peer
module tb_reg_alu_seq;
   import reg_alu_seq_pkg::*;
   logic clk = 0, reset = 0, instr_valid = 0, cout = 0;
   logic [15:0] instr = 0;
   logic instr_ready, sel, wr, carry_flag, done, halted;
   logic [1:0] op;
   logic [2:0] rd_addr_a, rd_addr_b, wr_addr;
   logic [15:0] d_in, retired;
   int checks = 0, errors = 0, cyc = 0, sent = 0;
   logic [15:0] rf [8];
   logic [15:0] mreg [8];

   typedef struct {
      logic [1:0]  kind;
      logic [1:0]  op;
      logic [2:0]  rd, ra, rb;
      logic [15:0] val;
      logic        carry;
      int          acc;
   } exp_t;
   exp_t q[$];

   reg_alu_seq dut (
      .clk(clk), .reset(reset), .instr_valid(instr_valid), .instr(instr), .instr_ready(instr_ready),
      .sel(sel), .wr(wr), .op(op), .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b), .wr_addr(wr_addr),
      .d_in(d_in), .cout(cout), .carry_flag(carry_flag), .done(done), .halted(halted), .retired(retired)
   );

   always #5 clk = ~clk;

   function automatic logic [16:0] alu(input logic [1:0] o, input logic [15:0] a, input logic [15:0] b);
      case (o)
         2'b00:   return {1'b0, a} + {1'b0, b};
         2'b01:   return {1'b0, a - b};
         2'b10:   return {1'b0, a & b};
         default: return {1'b0, a ^ b};
      endcase
   endfunction

   initial foreach (rf[i]) begin rf[i] = '0; mreg[i] = '0; end

   // Stand-in for reg_alu: register file plus a carry registered every cycle.
   always @(posedge clk) begin
      logic [16:0] r;
      r = alu(op, rf[rd_addr_a], rf[rd_addr_b]);
      cout <= r[16];
      if (wr) rf[wr_addr] <= sel ? d_in : r[15:0];
   end
   always @(posedge clk) cyc = cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [15:0] ldi(input logic [2:0] rd, input logic [10:0] imm);
      return {2'b01, rd, imm};
   endfunction
   function automatic logic [15:0] aluw(input logic [1:0] o, input logic [2:0] rd, input logic [2:0] ra, input logic [2:0] rb);
      return {2'b00, o, rd, ra, rb, 3'b000};
   endfunction

   task automatic model(input logic [15:0] w);
      exp_t e;
      logic [16:0] r;
      e.kind = w[15:14]; e.op = w[13:12]; e.ra = w[8:6]; e.rb = w[5:3];
      e.rd = e.kind == KIND_LDI ? w[13:11] : w[11:9];
      e.val = '0; e.carry = 0; e.acc = cyc + 1;
      if (e.kind == KIND_LDI) begin
         e.val = {5'b0, w[10:0]};
         mreg[e.rd] = e.val;
      end else if (e.kind == KIND_ALU) begin
         r = alu(e.op, mreg[e.ra], mreg[e.rb]);
         e.val = r[15:0]; e.carry = r[16];
         mreg[e.rd] = e.val;
      end
      q.push_back(e);
   endtask

   // Monitor: checks every write and every done against the head of the queue.
   logic pend = 0, pend_alu = 0, pend_c = 0, head_wr = 0;
   logic [2:0] pend_rd = 0;
   logic [15:0] pend_val = 0, mon_ret = 0;
   always @(negedge clk) begin
      if (!reset) begin
         mon_ret = 0; pend = 0; head_wr = 0;
      end else begin
         if (pend) begin
            chk("regval", rf[pend_rd], pend_val);
            if (pend_alu) chk("carry_flag", carry_flag, pend_c);
            pend = 0;
         end
         if (wr) begin
            if (q.size() == 0) chk("spurious_wr", 1, 0);
            else begin
               chk("wr_time", cyc, q[0].acc + (q[0].kind == KIND_ALU ? 1 : 0));
               chk("wr_addr", wr_addr, q[0].rd);
               chk("sel", sel, q[0].kind == KIND_LDI);
               if (q[0].kind == KIND_LDI) chk("d_in", d_in, q[0].val);
               else begin
                  chk("rd_addr_a", rd_addr_a, q[0].ra);
                  chk("rd_addr_b", rd_addr_b, q[0].rb);
                  chk("op", op, q[0].op);
               end
               head_wr = 1;
            end
         end
         if (done) begin
            if (q.size() == 0) chk("spurious_done", 1, 0);
            else begin
               exp_t e;
               e = q.pop_front();
               chk("done_time", cyc, e.acc + (e.kind == KIND_ALU ? 2 : 0));
               chk("wr_seen", head_wr, e.kind == KIND_ALU || e.kind == KIND_LDI);
               chk("retired", retired, mon_ret);
               mon_ret++;
               head_wr = 0;
               if (e.kind == KIND_ALU || e.kind == KIND_LDI) begin
                  pend = 1; pend_alu = e.kind == KIND_ALU; pend_c = e.carry;
                  pend_rd = e.rd; pend_val = e.val;
               end
            end
         end
      end
   end

   // Waits for ready while offering junk (which must be ignored), then transfers w.
   task automatic issue(input logic [15:0] w);
      int n = 0;
      @(negedge clk);
      while (!instr_ready) begin
         instr_valid = 1; instr = 16'($urandom);
         if (++n > 50) begin chk("ready_timeout", 0, 1); return; end
         @(negedge clk);
      end
      instr_valid = 1; instr = w;
      model(w);
      sent++;
      @(posedge clk);
   endtask

   task automatic drain();
      int n = 0;
      @(negedge clk);
      instr_valid = 0;
      while (q.size() != 0 || pend) begin
         if (++n > 50) begin chk("drain_timeout", q.size(), 0); q.delete(); return; end
         @(negedge clk);
      end
   endtask

   initial begin
      logic [15:0] w;
      repeat (3) @(negedge clk);
      chk("rst_wr", wr, 0);
      chk("rst_ready", instr_ready, 1);
      chk("rst_retired", retired, 0);
      chk("rst_carry", carry_flag, 0);
      chk("rst_halted", halted, 0);
      reset = 1;

      issue(16'h5805);
      drain();
      chk("ldi_retired", retired, 1);
      chk("ldi_r3", rf[3], 16'h0005);

      issue(ldi(1, 11'h7FF)); issue(ldi(2, 11'h001)); issue(aluw(2'b00, 4, 1, 2));
      drain();
      chk("add_r4", rf[4], 16'h0800);
      chk("add_carry0", carry_flag, 0);

      issue(ldi(1, 11'h7FF));
      repeat (5) issue(aluw(2'b00, 1, 1, 1));
      issue(aluw(2'b00, 5, 1, 1));
      drain();
      chk("dbl_r1", rf[1], 16'hFFE0);
      chk("dbl_r5", rf[5], 16'hFFC0);
      chk("dbl_carry1", carry_flag, 1);

      for (int i = 0; i < 120; i++) begin
         if ($urandom_range(0, 4) == 0) begin @(negedge clk); instr_valid = 0; end
         w = 16'($urandom);
         w[15:14] = 2'($urandom_range(0, 2));
         issue(w);
      end
      drain();
      chk("rand_retired", retired, 16'(sent));

      issue(ldi(1, 11'h001)); issue(ldi(2, 11'h002)); issue(ldi(6, 11'h234));
      drain();
      issue(aluw(2'b00, 6, 1, 2));
      @(negedge clk); instr_valid = 0;
      @(negedge clk);
      chk("exec_wr", wr, 1);
      #1 reset = 0; #1;
      chk("mid_rst_wr", wr, 0);
      chk("mid_rst_ready", instr_ready, 1);
      chk("mid_rst_retired", retired, 0);
      chk("mid_rst_carry", carry_flag, 0);
      q.delete(); mreg[6] = 16'h0234; sent = 0;
      repeat (3) @(negedge clk);
      reset = 1;
      @(negedge clk);
      chk("mid_rst_r6", rf[6], 16'h0234);

      issue(ldi(7, 11'h0AB));
      drain();
      chk("post_rst_retired", retired, 1);
      chk("post_rst_r7", rf[7], 16'h00AB);

      issue(16'hC000);
      drain();
      chk("halted", halted, 1);
      for (int i = 0; i < 8; i++) begin
         instr_valid = 1; instr = ldi(0, 11'h3FF);
         @(negedge clk);
         chk("halt_ready", instr_ready, 0);
         chk("halt_wr", wr, 0);
      end
      instr_valid = 0;
      chk("halt_retired", retired, 2);
      chk("halt_still", halted, 1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
